// File: rtl/sample_uart_framer.sv
// sample_uart_framer: snapshots four 16-bit channels on a sample_clk edge and streams a 20-byte frame to uart_tx
module sample_uart_framer #(
  parameter int DECIMATE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_clk,
  input  logic [15:0] sample_in0,
  input  logic [15:0] sample_in1,
  input  logic [15:0] sample_in2,
  input  logic [15:0] sample_in3,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [7:0]  dropped
);
  typedef enum logic [1:0] {IDLE, SEND, ARM, DRAIN} state_t;
  localparam logic [7:0] DMAX = 8'(DECIMATE - 1);
  state_t state_q, state_d;
  logic sample_clk_q;
  logic [7:0] decim_q, decim_d;
  logic [4:0] idx_q, idx_d;
  logic [3:0][15:0] snap_q, snap_d;
  logic tx_start_q, tx_start_d, busy_q, busy_d;
  logic [7:0] tx_data_q, tx_data_d, drop_q, drop_d;
  logic [15:0] fc_q, fc_d;
  logic edge_det, start_req, send_go, drain_go;
  logic [1:0] ch;
  logic [4:0] pos;
  logic [7:0] byte_sel;
  assign edge_det  = sample_clk & ~sample_clk_q;
  assign start_req = enable & edge_det & (decim_q == 8'd0);
  assign send_go   = (state_q == SEND) & ~tx_busy;
  assign drain_go  = (state_q == DRAIN) & ~tx_busy;
  assign ch        = idx_q < 5'd5 ? 2'd0 : idx_q < 5'd10 ? 2'd1 : idx_q < 5'd15 ? 2'd2 : 2'd3;
  assign pos       = idx_q - 5'(ch) * 5'd5;
  assign byte_sel  = pos == 5'd0 ? 8'h43 : pos == 5'd1 ? 8'h48 : pos == 5'd2 ? {6'b001100, ch} :
                     pos == 5'd3 ? snap_q[ch][15:8] : snap_q[ch][7:0];
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign frame_count = fc_q;
  assign dropped     = drop_q;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  // next state: one handshake per byte, ARM gives uart_tx a cycle to raise tx_busy
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_req ? SEND : IDLE;
      SEND:    state_d = tx_busy ? SEND : ARM;
      ARM:     state_d = DRAIN;
      DRAIN:   state_d = tx_busy ? DRAIN : idx_q == 5'd19 ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end
  // outputs and datapath next values; a start request outside IDLE is counted as dropped
  always_comb begin
    decim_d    = !enable ? 8'd0 : edge_det ? (decim_q == DMAX ? 8'd0 : decim_q + 8'd1) : decim_q;
    snap_d     = (state_q == IDLE && start_req) ? {sample_in3, sample_in2, sample_in1, sample_in0} : snap_q;
    idx_d      = state_q == IDLE ? 5'd0 : (drain_go && idx_q != 5'd19) ? idx_q + 5'd1 : idx_q;
    tx_start_d = send_go;
    tx_data_d  = send_go ? byte_sel : tx_data_q;
    fc_d       = (drain_go && idx_q == 5'd19) ? fc_q + 16'd1 : fc_q;
    drop_d     = (start_req && state_q != IDLE && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    busy_d     = state_d != IDLE;
  end
  // datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_clk_q <= 1'b0;
      decim_q      <= 8'd0;
      snap_q       <= '0;
      idx_q        <= 5'd0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      fc_q         <= 16'd0;
      drop_q       <= 8'd0;
      busy_q       <= 1'b0;
    end else begin
      sample_clk_q <= sample_clk;
      decim_q      <= decim_d;
      snap_q       <= snap_d;
      idx_q        <= idx_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      fc_q         <= fc_d;
      drop_q       <= drop_d;
      busy_q       <= busy_d;
    end
  end
endmodule

// File: doc/sample_uart_framer.md
Name: sample_uart_framer

Overview:
- Upstream stage of uart_tx: turns calibrated per-channel samples into the debug byte stream sent over UART.
- Takes a coherent snapshot of all 4 channels on a sample_clk rising edge.
- Serialises the snapshot as a 20-byte frame, one byte per uart_tx handshake.
- Replaces per-byte ad-hoc channel rotation with whole-frame snapshots, decimation and drop accounting.

Parameters:
DECIMATE, 1, frame-start period in accepted sample_clk rising edges (legal 1..256)

Ports:
clk  input  1  system clock; sole clock domain
rst  input  1  synchronous active-high reset
enable  input  1  permits new frames; a frame in progress always completes
sample_clk  input  1  sample strobe, same clock domain as clk; rising edge detected internally
sample_in0  input  16  calibrated channel 0 sample, two's complement
sample_in1  input  16  channel 1
sample_in2  input  16  channel 2
sample_in3  input  16  channel 3
tx_busy  input  1  from uart_tx; goes high the cycle after tx_start is sampled, low when ready
tx_start  output  1  one-cycle request to uart_tx
tx_data  output  8  byte for uart_tx, valid while tx_start high
busy  output  1  high whenever state != IDLE
frame_count  output  16  completed frames, wraps at 0xFFFF
dropped  output  8  frame starts lost to a frame in progress, saturates at 255

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, tx_start=0, tx_data=0x00, frame_count=0, dropped=0, decim_cnt=0, sample_clk_q=0, byte_idx=0. rst has priority over all other events.
- Edge detect: edge = sample_clk & ~sample_clk_q. sample_clk_q is registered every cycle.
- Decimation:
  - While enable=0: decim_cnt forced to 0; no frame starts.
  - While enable=1: each edge advances decim_cnt modulo DECIMATE.
  - A start request is an edge with decim_cnt==0 (evaluated before the increment).
- All outputs registered. State machine:
  - IDLE: on start request, capture sample_in0..3 into snapshot regs, byte_idx<=0, go SEND. busy rises the next cycle.
  - SEND: if tx_busy=0, then tx_start<=1, tx_data<=byte(byte_idx), go ARM; else stay.
  - ARM: tx_start<=0 (high exactly one cycle), go DRAIN. This gives uart_tx one cycle to raise tx_busy.
  - DRAIN: wait for tx_busy=0.
    - If byte_idx==19: frame_count++, go IDLE.
    - Else: byte_idx++, go SEND.
- Latency: edge in cycle N, snapshot at end of N. With tx_busy low, tx_start is first high in cycle N+2. Minimum spacing between tx_start pulses is 3 cycles.
- Frame layout (byte_idx 0..19), channel k=0..3, 5 bytes each:
  - 0x43 'C'
  - 0x48 'H'
  - 0x30+k
  - snap_k[15:8]
  - snap_k[7:0]
- Snapshot coherence: sample_in changes after capture do not affect the frame in progress.
- Overrun: a start request while state != IDLE is dropped. dropped++ saturating at 255, cleared only by rst.
- No start request is accepted in the same cycle a frame returns to IDLE; the next start requires a later edge.
- enable falling mid-frame: frame completes normally; no new frames start.
- rst mid-frame: tx_start=0 from the next cycle, snapshot discarded, no partial-frame count. A byte already handed to uart_tx finishes on the line; the host resyncs on "CH".
- Non-edge cycles where sample_clk is held high produce no further start requests.

Test Plan:
1. Reset and idle:
   - Stimulus: hold rst 3 cycles with random inputs.
   - Required: tx_start=0, tx_data=0x00, busy=0, frame_count=0, dropped=0; no tx_start until the first edge with enable=1.
2. Single frame:
   - Stimulus: DECIMATE=1; inputs 0x1234, 0xABCD, 0x8000, 0x7FFF; uart model busy 10 cycles per byte.
   - Required: exactly 20 bytes: 43 48 30 12 34, 43 48 31 AB CD, 43 48 32 80 00, 43 48 33 7F FF; frame_count=1; first tx_start at edge cycle+2.
3. Coherence and overrun:
   - Stimulus: after capture, change all inputs to 0x0000 and pulse sample_clk 3 times during the frame.
   - Required: bytes still match the captured values; dropped=3; frame_count=1.
4. Decimation:
   - Stimulus: DECIMATE=4; 8 well-spaced edges, tx_busy never asserted.
   - Required: frames start on edges 1 and 5 only; frame_count=2; dropped=0.
5. Saturation and reset:
   - Stimulus: 300 edges during one long frame.
   - Required: dropped=255.
   - Stimulus: assert rst at byte_idx=7.
   - Required: tx_start=0 next cycle, busy=0, dropped=0, frame_count unchanged from reset (0).
6. Enable gating:
   - Stimulus: deassert enable at byte_idx=4.
   - Required: frame completes (20 bytes); no new frame while enable=0; on re-enable, the first edge starts a frame.
